// File: rtl/data_mem_responder.sv
// Data-memory responder: one word request at a time over req/ready, WAIT_CYCLES wait
// states, one-cycle ack with rdata/err. Define DATA_MEM_ALIGN_CHECK_EN to reject misaligned addresses.
module data_mem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on a rising edge where req && ready; the requester
    // holds req (and its payload) until then. Inputs are ignored while ready is low, and
    // each accepted request yields exactly one ack pulse, with err and rdata qualified by ack.

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      wait_cnt;
    logic            lat_we;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_wdata;
    logic [31:0]     mem [DEPTH];

    logic                  acc_we;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  range_err;
    logic                  align_err;
    logic                  acc_err;
    logic                  go_resp;
    logic                  mem_wr;

    // With zero wait states the access happens on the acceptance edge itself, so the
    // live inputs stand in for the not-yet-latched request.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        if (state == ST_IDLE) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
        end
    end

    assign acc_idx   = acc_addr[DEPTH_LOG2+1:2];
    assign range_err = (acc_addr >> (DEPTH_LOG2 + 2)) != 32'd0;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    assign align_err = acc_addr[1:0] != 2'b00;
`else
    assign align_err = 1'b0;
`endif

    assign acc_err = range_err | align_err;
    assign go_resp = ((state == ST_IDLE) && req && (WAIT_CYCLES == 0))
                   || ((state == ST_WAIT) && (wait_cnt == 4'd1));
    // Gating on rst keeps a request held through reset from writing the array.
    assign mem_wr  = rst && go_resp && acc_we && !acc_err;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ready     <= 1'b1;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
            wait_cnt  <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack <= 1'b0;
                    err <= 1'b0;
                    if (req) begin
                        lat_we    <= we;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        wait_cnt  <= WAIT_INIT;
                        ready     <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    ack   <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    ack   <= 1'b0;
                    err   <= 1'b0;
                end
            endcase

            // Entry into RESP overrides the per-state updates above.
            if (go_resp) begin
                state <= ST_RESP;
                ack   <= 1'b1;
                err   <= acc_err;
                if (acc_err) begin
                    rdata <= 32'd0;
                end else if (!acc_we) begin
                    rdata <= mem[acc_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a zero-wait and a two-wait instance driven by directed
// steps and random traffic, checked against a word-array model of the memory.
module tb_data_mem_responder;

    localparam int DL     = 10;
    localparam int DEPTH  = 1 << DL;
    localparam int WAIT_A = 0;
    localparam int WAIT_B = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_v   [2];
    logic        we_v    [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic        ready_v [2];
    logic        ack_v   [2];
    logic        err_v   [2];
    logic [31:0] rdata_v [2];
    logic [1:0]  dbg_v   [2];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q [$];
    logic [31:0] model_mem [int];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WAIT_A)) u_dut0 (
        .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .ready(ready_v[0]), .ack(ack_v[0]), .rdata(rdata_v[0]),
        .err(err_v[0]), .dbg_state(dbg_v[0])
    );

    data_mem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WAIT_B)) u_dut1 (
        .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .ready(ready_v[1]), .ack(ack_v[1]), .rdata(rdata_v[1]),
        .err(err_v[1]), .dbg_state(dbg_v[1])
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? WAIT_A : WAIT_B;
    endfunction

    function automatic int mkey(input int d, input logic [31:0] a);
        return d * 65536 + int'((a >> 2) & 32'(DEPTH - 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance d, starting in the cycle after the previous ack.
    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
        logic        e;
        logic [32:0] exp;
        int          n;
        bit          got;
        @(negedge clk);
        check("idle_ready", 32'(ready_v[d]), 32'd1);
        check("idle_ack", 32'(ack_v[d]), 32'd0);
        e = a >= (32'd1 << (DL + 2));
`ifdef DATA_MEM_ALIGN_CHECK_EN
        if ((a % 4) != 0) e = 1'b1;
`endif
        if (e) last_rd[d] = 32'd0;
        else if (w) model_mem[mkey(d, a)] = wd;
        else last_rd[d] = model_mem[mkey(d, a)];
        exp_q.push_back({e, last_rd[d]});
        req_v[d] = 1'b1; we_v[d] = w; addr_v[d] = a; wdata_v[d] = wd;
        @(posedge clk);
        #1;
        // Keep req asserted with junk payload: it must be ignored until the next idle cycle.
        we_v[d] = 1'($urandom); addr_v[d] = $urandom; wdata_v[d] = $urandom;
        got = 0;
        n = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (ack_v[d] === 1'b1) got = 1;
            else check("wait_ready", 32'(ready_v[d]), 32'd0);
        end
        req_v[d] = 1'b0;
        exp = exp_q.pop_front();
        check("ack_seen", 32'(got), 32'd1);
        if (got) begin
            check("latency", 32'(n), 32'(wait_of(d) + 1));
            check("err", 32'(err_v[d]), 32'(exp[32]));
            check("rdata", rdata_v[d], exp[31:0]);
            check("ack_ready", 32'(ready_v[d]), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        w;
        logic [31:0] a;
        int          word;
        for (int d = 0; d < 2; d++) begin
            req_v[d] = 1'b0; we_v[d] = 1'b0; addr_v[d] = 32'd0; wdata_v[d] = 32'd0;
            last_rd[d] = 32'd0;
        end

        // Reset and idle
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(ready_v[d]), 32'd1);
            check("rst_ack", 32'(ack_v[d]), 32'd0);
            check("rst_err", 32'(err_v[d]), 32'd0);
            check("rst_rdata", rdata_v[d], 32'd0);
        end
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_no_ack0", 32'(ack_v[0]), 32'd0);
            check("idle_no_ack1", 32'(ack_v[1]), 32'd0);
        end
        check("idle_ready_after", 32'(ready_v[1]), 32'd1);

        // Store then load with two wait states
        txn(1, 1'b1, 32'h10, 32'hDEADBEEF);
        txn(1, 1'b0, 32'h10, 32'h0);

        // Zero wait: store, load, then back-to-back accepts
        txn(0, 1'b1, 32'h0, 32'h12345678);
        txn(0, 1'b0, 32'h0, 32'h0);
        txn(0, 1'b0, 32'h0, 32'h0);

        // Out of range leaves the array untouched
        txn(1, 1'b1, 32'h0, 32'hCAFEF00D);
        txn(1, 1'b1, 32'h00001000, 32'h1);
        txn(1, 1'b0, 32'h0, 32'h0);
        txn(0, 1'b1, 32'hFFFFFFFC, 32'h5);
        txn(0, 1'b0, 32'h0, 32'h0);

        // Misaligned load of word 4
        txn(1, 1'b0, 32'h13, 32'h0);

        // Reset during WAIT aborts the store
        txn(1, 1'b1, 32'h20, 32'h11112222);
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 32'h20; wdata_v[1] = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        req_v[1] = 1'b0;
        @(negedge clk);
        check("mid_wait_ready", 32'(ready_v[1]), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready_v[1]), 32'd1);
        check("mid_rst_ack", 32'(ack_v[1]), 32'd0);
        check("mid_rst_rdata", rdata_v[1], 32'd0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_no_ack", 32'(ack_v[1]), 32'd0);
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("aborted_no_ack", 32'(ack_v[1]), 32'd0);
        end
        txn(1, 1'b0, 32'h20, 32'h0);

        // Random traffic on both instances
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                w = 1'($urandom_range(0, 1));
                word = $urandom_range(0, 15) + (($urandom_range(0, 1) == 1) ? (DEPTH - 16) : 0);
                a = 32'(word * 4 + $urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a = 32'h00001000 | $urandom;
                if (!w && a < 32'h1000 && !model_mem.exists(mkey(d, a))) w = 1'b1;
                txn(d, w, a, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
